// File: rtl/irq_pkg.sv
// ============================================================================
// Module      : irq_pkg
// Description : Shared constants and helpers for the interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_pkg;

  localparam logic [3:0] OFF_PENDING   = 4'd0;
  localparam logic [3:0] OFF_MASK      = 4'd1;
  localparam logic [3:0] OFF_MODE      = 4'd2;
  localparam logic [3:0] OFF_INSERVICE = 4'd3;
  localparam logic [3:0] OFF_CLAIM     = 4'd4;
  localparam logic [3:0] OFF_EOI       = 4'd5;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

  localparam int CLAIM_V_BIT = 31;

  // The id is zero-extended by the caller; the valid flag lands in the top bit.
  function automatic logic [31:0] claim_word(input logic valid, input logic [31:0] id);
    logic [31:0] w;
    w = id;
    w[CLAIM_V_BIT] = valid;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// ============================================================================
// Module      : irq_prio_enc
// Description : Lowest-index-first priority encoder (vector -> id, valid).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_prio_enc #(
  parameter int W    = 16,
  parameter int ID_W = 5
) (
  input  logic [W-1:0]    i_vec,
  output logic [ID_W-1:0] o_id,
  output logic            o_valid
);

  // Scanning downward lets the lowest set index overwrite everything above it.
  always_comb begin
    o_id    = '0;
    o_valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_id    = ID_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_controller.sv
// ============================================================================
// Module      : irq_controller
// Description : Programmable interrupt controller with edge/level modes,
//               masking, nested in-service priority and claim/EOI handshake.
//               Optional input synchronizer enabled by defining IRQ_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_controller
  import irq_pkg::*;
#(
  parameter int N_SRC = 16,
  parameter int N_OUT = 6,
  parameter int ID_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [3:0]       bus_addr,
  input  logic             bus_re,
  input  logic             bus_we,
  input  logic [31:0]      bus_wd,
  output logic [31:0]      bus_rd,
  output logic [N_OUT-1:0] hwint_out
);

  logic [N_SRC-1:0] irq_s;
  logic [N_SRC-1:0] prev_q, prev_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] in_service_q, in_service_d;
  logic [N_OUT-1:0] hwint_q, hwint_d;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] below_top;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] claim_oh;
  logic [N_SRC-1:0] eoi_oh;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] edge_next;
  logic [N_SRC-1:0] wd_src;

  logic [ID_W-1:0]  ceil_id;
  logic             ceil_v;
  logic [ID_W-1:0]  active_id;
  logic             active_v;

  logic             wr_pending;
  logic             wr_mask;
  logic             wr_mode;
  logic             claim_fire;
  logic             eoi_fire;
  logic             unused_wd;

`ifdef IRQ_SYNC_EN
  logic [N_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_src;
`endif

  // Upper write-data bits beyond the source count have no storage behind them.
  assign unused_wd = ^bus_wd;
  assign wd_src    = bus_wd[N_SRC-1:0];

  irq_prio_enc #(
    .W    (N_SRC),
    .ID_W (ID_W)
  ) u_ceiling (
    .i_vec   (in_service_q),
    .o_id    (ceil_id),
    .o_valid (ceil_v)
  );

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      below_top[i] = !ceil_v || (i < int'(ceil_id));
    end
  end

  assign eligible = pending_q & mask_q & below_top;

  irq_prio_enc #(
    .W    (N_SRC),
    .ID_W (ID_W)
  ) u_active (
    .i_vec   (eligible),
    .o_id    (active_id),
    .o_valid (active_v)
  );

  assign rise       = irq_s & ~prev_q;
  assign wr_pending = bus_we && (bus_addr == OFF_PENDING);
  assign wr_mask    = bus_we && (bus_addr == OFF_MASK);
  assign wr_mode    = bus_we && (bus_addr == OFF_MODE);
  assign claim_fire = bus_re && (bus_addr == OFF_CLAIM) && active_v;
  assign eoi_fire   = bus_we && (bus_addr == OFF_EOI);

  // Ids that do not match any source simply produce an empty one-hot.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      claim_oh[i] = claim_fire && (active_id == ID_W'(i));
      eoi_oh[i]   = eoi_fire && (bus_wd[ID_W-1:0] == ID_W'(i));
    end
  end

  always_comb begin
    prev_d       = irq_s;
    mask_d       = wr_mask ? wd_src : mask_q;
    mode_d       = wr_mode ? wd_src : mode_q;
    in_service_d = (in_service_q & ~eoi_oh) | claim_oh;

    w1c       = wr_pending ? wd_src : '0;
    edge_next = (pending_q & ~(w1c | claim_oh)) | rise;
    for (int i = 0; i < N_SRC; i++) begin
      pending_d[i] = (mode_q[i] == MODE_EDGE) ? edge_next[i] : irq_s[i];
    end
    // Switching a source's mode discards whatever it had latched.
    if (wr_mode) begin
      pending_d = pending_d & ~(wd_src ^ mode_q);
    end

    hwint_d = '0;
    for (int k = 0; k < N_OUT; k++) begin
      for (int i = 0; i < N_SRC; i++) begin
        if ((i % N_OUT) == k) begin
          hwint_d[k] = hwint_d[k] | eligible[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q       <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      mode_q       <= '0;
      in_service_q <= '0;
      hwint_q      <= '0;
    end else begin
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      mode_q       <= mode_d;
      in_service_q <= in_service_d;
      hwint_q      <= hwint_d;
    end
  end

  assign hwint_out = hwint_q;

  always_comb begin
    bus_rd = '0;
    case (bus_addr)
      OFF_PENDING:   bus_rd = 32'(pending_q);
      OFF_MASK:      bus_rd = 32'(mask_q);
      OFF_MODE:      bus_rd = 32'(mode_q);
      OFF_INSERVICE: bus_rd = 32'(in_service_q);
      OFF_CLAIM:     bus_rd = claim_word(active_v, 32'(active_id));
      default:       bus_rd = '0;
    endcase
  end

endmodule

`default_nettype wire
